// File: rtl/systolic_pkg.sv
// Shared definitions for the 1x4 systolic row: sizes, latency defaults and
// the result-drain state encoding. The operand feeder imports this package too.
package systolic_pkg;

  localparam int ACC_W_DEF  = 32;
  localparam int N_PE       = 4;
  localparam int PE_LAT_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } drain_state_e;

  // Capture-counter value at which PE n holds its final accumulator:
  // the PE pipeline latency plus n cycles of b-cascade skew.
  function automatic logic [3:0] cap_tap(input int pe_lat, input int n);
    return 4'(pe_lat + n);
  endfunction

endpackage

// File: rtl/systolic1x4_drain.sv
// Result-readout end of the 1x4 systolic row. After the last operand beat it
// samples each PE accumulator at that PE's skewed completion cycle, then streams
// the four words out over a valid/ready handshake (index 0 first).
module systolic1x4_drain
  import systolic_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int PE_LAT = PE_LAT_DEF   // legal range 1..8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_last,
  input  logic [ACC_W-1:0] c0,
  input  logic [ACC_W-1:0] c1,
  input  logic [ACC_W-1:0] c2,
  input  logic [ACC_W-1:0] c3,
  output logic [ACC_W-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
  localparam logic [1:0] S_DRAIN   = ST_DRAIN;

  // The last PE completes last; its capture ends the CAPTURE phase.
  localparam logic [3:0] LAST_TAP = cap_tap(PE_LAT, N_PE - 1);

  logic [1:0]       state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic [1:0]       idx_reg, idx_next;
  logic             overrun_reg, overrun_next;
  logic [ACC_W-1:0] cap_reg [N_PE];
  logic [ACC_W-1:0] c_vec   [N_PE];
  logic             drain_active;

  assign c_vec[0] = c0;
  assign c_vec[1] = c1;
  assign c_vec[2] = c2;
  assign c_vec[3] = c3;

  // Next-state logic for the IDLE -> CAPTURE -> DRAIN job sequence.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (acc_last) begin
          state_next = S_CAPTURE;
          cnt_next   = 4'd1;
        end
      end
      S_CAPTURE: begin
        // Capture timing is free-running; the downstream cannot stall it.
        cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == LAST_TAP) begin
          state_next = S_DRAIN;
          cnt_next   = 4'd0;
          idx_next   = 2'd0;
        end
      end
      S_DRAIN: begin
        // out_valid is implied by the DRAIN state, so ready alone means a transfer.
        if (out_ready) begin
          idx_next = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            state_next = S_IDLE;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = 4'd0;
        idx_next   = 2'd0;
      end
    endcase
  end

  // Sticky overrun flag: a new job request while busy is dropped and flagged;
  // a clear in the same cycle wins.
  always_comb begin
    overrun_next = overrun_reg;
    if (clr_ovr) begin
      overrun_next = 1'b0;
    end else if (acc_last && (state_reg != S_IDLE)) begin
      overrun_next = 1'b1;
    end
  end

  // State, counters and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 4'd0;
      idx_reg     <= 2'd0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      overrun_reg <= overrun_next;
    end
  end

  // Capture register file: PE n is sampled when the counter hits its tap.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_PE; n++) begin
        cap_reg[n] <= '0;
      end
    end else if (state_reg == S_CAPTURE) begin
      for (int n = 0; n < N_PE; n++) begin
        if (cnt_reg == cap_tap(PE_LAT, n)) begin
          cap_reg[n] <= c_vec[n];
        end
      end
    end
  end

  // Outputs decode registered state only, so nothing combinational reaches
  // out_valid from out_ready; data/idx are zero outside DRAIN.
  assign drain_active = (state_reg == S_DRAIN);
  assign out_valid    = drain_active;
  assign out_data     = drain_active ? cap_reg[idx_reg] : '0;
  assign out_idx      = drain_active ? idx_reg : 2'd0;
  assign out_last     = drain_active && (idx_reg == 2'd3);
  assign busy         = (state_reg != S_IDLE);
  assign overrun      = overrun_reg;

endmodule

// File: tb/tb_systolic1x4_drain.sv
// Bench for systolic1x4_drain: two instances (PE_LAT=1 and PE_LAT=3) share the
// data/ready/clear/reset inputs; each has its own acc_last. A timestamp model
// (word n of a job = value of c_n held before edge E0+PE_LAT+n; valid from edge
// E0+PE_LAT+4 until the 4th accepted word) is compared every cycle.
module tb_systolic1x4_drain;

  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  acc_last = 2'b00;
  logic        clr_ovr = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0;

  logic [31:0] o_data [2];
  logic [1:0]  o_idx  [2];
  logic [1:0]  o_valid, o_last, o_busy, o_ovr;

  systolic1x4_drain #(.ACC_W(32), .PE_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .acc_last(acc_last[0]),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .out_data(o_data[0]), .out_idx(o_idx[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready), .out_last(o_last[0]), .busy(o_busy[0]),
    .overrun(o_ovr[0]), .clr_ovr(clr_ovr)
  );

  systolic1x4_drain #(.ACC_W(32), .PE_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .acc_last(acc_last[1]),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .out_data(o_data[1]), .out_idx(o_idx[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready), .out_last(o_last[1]), .busy(o_busy[1]),
    .overrun(o_ovr[1]), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  int pos_cnt = 0;
  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL u%0d.%s: got %0d, expected %0d (edge %0d)", k, name, act, exp, pos_cnt);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] hist [HMAX][4];
  bit          m_act [2] = '{0, 0};
  int          m_e0  [2] = '{0, 0};
  int          m_x   [2] = '{0, 0};
  bit          m_ovr [2] = '{0, 0};
  int          m_lat [2] = '{1, 3};

  int          mon = 0;
  int          first_v = -1;
  logic [31:0] got_d [$];
  logic [1:0]  got_i [$];
  logic        got_l [$];

  initial begin : scoreboard
    int u;
    bit ev, was;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      u = pos_cnt + 1;   // number of the edge these inputs will be sampled at
      if (u < HMAX) begin
        hist[u][0] = c0; hist[u][1] = c1; hist[u][2] = c2; hist[u][3] = c3;
      end
      for (int k = 0; k < 2; k++) begin
        ev = m_act[k] && (u >= m_e0[k] + m_lat[k] + 4);
        ed = ev ? hist[m_e0[k] + m_lat[k] + m_x[k]][m_x[k]] : 32'd0;
        chk(k, "valid",   32'(o_valid[k]), 32'(ev));
        chk(k, "data",    o_data[k],       ed);
        chk(k, "idx",     32'(o_idx[k]),   ev ? 32'(m_x[k]) : 32'd0);
        chk(k, "last",    32'(o_last[k]),  32'(ev && m_x[k] == 3));
        chk(k, "busy",    32'(o_busy[k]),  32'(m_act[k]));
        chk(k, "overrun", 32'(o_ovr[k]),   32'(m_ovr[k]));
        if (k == mon && o_valid[k]) begin
          if (first_v < 0) first_v = u;
          if (out_ready) begin
            got_d.push_back(o_data[k]);
            got_i.push_back(o_idx[k]);
            got_l.push_back(o_last[k]);
          end
        end
        // advance the model across edge u
        if (rst) begin
          m_act[k] = 0; m_x[k] = 0; m_ovr[k] = 0;
        end else begin
          was = m_act[k];
          if (ev && out_ready) begin
            m_x[k]++;
            if (m_x[k] == 4) m_act[k] = 0;
          end
          if (acc_last[k] && !was) begin
            m_act[k] = 1; m_e0[k] = u; m_x[k] = 0;
          end
          if (clr_ovr) m_ovr[k] = 0;
          else if (acc_last[k] && was) m_ovr[k] = 1;
        end
      end
    end
  end

  initial begin : watchdog
    #70000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  int cmode = 0;      // 0 random, 1 ramp, 2 PE-row model
  int pe_e0 = 0;
  int cur_stall = 0;  // <0: random ready
  int tcount = 0;

  function automatic int beats_done(input int k_rel, input int n);
    int v;
    v = k_rel - n + 2;
    if (v < 0) v = 0;
    if (v > 3) v = 3;
    return v;
  endfunction

  task automatic tick();
    int u;
    logic [31:0] cv [4];
    @(posedge clk);
    #1;
    u = pos_cnt + 1;
    for (int n = 0; n < 4; n++) begin
      case (cmode)
        1:       cv[n] = 32'(100 * n + u);
        2:       cv[n] = 32'((n + 1) * 5 * beats_done(u - pe_e0, n));
        default: cv[n] = $urandom;
      endcase
    end
    c0 = cv[0]; c1 = cv[1]; c2 = cv[2]; c3 = cv[3];
    tcount++;
    if (cur_stall < 0) out_ready = 1'($urandom_range(0, 1));
    else out_ready = ((tcount % (cur_stall + 1)) == cur_stall);
  endtask

  task automatic start_job(input int k, output int e0);
    acc_last[k] = 1'b1;
    e0 = pos_cnt + 1;
    tick();
    acc_last[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (o_busy[k] && n < 400) begin
      tick();
      n++;
    end
    chk(k, "drain_in_time", 32'(n < 400), 32'd1);
  endtask

  task automatic clear_mon(input int k);
    mon = k;
    first_v = -1;
    got_d.delete(); got_i.delete(); got_l.delete();
  endtask

  task automatic chk_order(input int k);
    chk(k, "xfer_count", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) begin
      for (int n = 0; n < 4; n++) begin
        chk(k, "xfer_idx",  32'(got_i[n]), 32'(n));
        chk(k, "xfer_last", 32'(got_l[n]), 32'(n == 3));
      end
    end
  endtask

  typedef struct {
    int sel;      // 0: PE_LAT=1 instance, 1: PE_LAT=3 instance
    int cm;       // c source
    int pre;      // idle cycles before acc_last
    int stall;    // ready duty: high 1 cycle in stall+1; <0 random
    int dup;      // second acc_last this many cycles after E0 (0 = none)
    bit clr;      // pulse clr_ovr afterwards
    bit exp_ovr;  // overrun expected after the job
  } row_t;

  row_t rows [8];

  initial begin : main
    int e0, e0b, n, b;
    rows[0] = '{0, 0, 2, 0, 0, 0, 0};
    rows[1] = '{0, 0, 1, 3, 0, 0, 0};
    rows[2] = '{0, 1, 3, 0, 0, 0, 0};
    rows[3] = '{1, 1, 2, 0, 0, 0, 0};
    rows[4] = '{0, 0, 1, 0, 2, 1, 1};
    rows[5] = '{1, 0, 2, -1, 5, 1, 1};
    rows[6] = '{1, 1, 1, 2, 0, 0, 0};
    rows[7] = '{0, 0, 4, -1, 0, 0, 0};

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk(0, "reset_data", o_data[0], 32'd0);

    // Basic: PE row with a=1..4, b0=5 for 3 beats, last beat at E0.
    clear_mon(0);
    cmode = 2; cur_stall = 0;
    pe_e0 = pos_cnt + 4;
    repeat (3) tick();
    start_job(0, e0);
    chk(0, "basic_e0", 32'(e0), 32'(pe_e0));
    wait_idle(0);
    chk_order(0);
    for (int i = 0; i < 4; i++) begin
      if (i < got_d.size()) chk(0, "basic_word", got_d[i], 32'(15 * (i + 1)));
    end
    chk(0, "first_valid_offset", 32'(first_v - e0), 32'd5);

    // Table-driven jobs.
    for (int r = 0; r < 8; r++) begin
      clear_mon(rows[r].sel);
      cmode = rows[r].cm;
      cur_stall = rows[r].stall;
      repeat (rows[r].pre) tick();
      start_job(rows[r].sel, e0);
      if (rows[r].dup > 0) begin
        repeat (rows[r].dup - 1) tick();
        acc_last[rows[r].sel] = 1'b1;
        tick();
        acc_last[rows[r].sel] = 1'b0;
      end
      wait_idle(rows[r].sel);
      chk_order(rows[r].sel);
      if (rows[r].cm == 1 && got_d.size() == 4) begin
        for (int i = 0; i < 4; i++)
          chk(rows[r].sel, "ramp_word", got_d[i], 32'(100 * i + e0 + m_lat[rows[r].sel] + i));
      end
      chk(rows[r].sel, "row_overrun", 32'(o_ovr[rows[r].sel]), 32'(rows[r].exp_ovr));
      if (rows[r].clr) begin
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk(rows[r].sel, "clr_overrun", 32'(o_ovr[rows[r].sel]), 32'd0);
      end
    end

    // Overrun set, then clr_ovr coincident with another overrun.
    clear_mon(0);
    cmode = 0; cur_stall = 0;
    start_job(0, e0);
    tick();
    acc_last[0] = 1'b1;
    tick();
    acc_last[0] = 1'b0;
    chk(0, "ovr_set", 32'(o_ovr[0]), 32'd1);
    acc_last[0] = 1'b1; clr_ovr = 1'b1;
    tick();
    acc_last[0] = 1'b0; clr_ovr = 1'b0;
    chk(0, "ovr_clr_wins", 32'(o_ovr[0]), 32'd0);
    wait_idle(0);
    chk_order(0);

    // Reset after the 2nd transfer of a drain.
    clear_mon(0);
    start_job(0, e0);
    n = 0; b = 0;
    while (n < 2 && b < 100) begin
      if (o_valid[0] && out_ready) n++;
      tick();
      b++;
    end
    chk(0, "reached_2nd_xfer", 32'(n), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(0, "rst_valid", 32'(o_valid[0]), 32'd0);
    chk(0, "rst_busy",  32'(o_busy[0]),  32'd0);
    chk(0, "rst_data",  o_data[0],       32'd0);
    chk(0, "rst_idx",   32'(o_idx[0]),   32'd0);
    chk(0, "rst_last",  32'(o_last[0]),  32'd0);
    tick();
    clear_mon(0);
    start_job(0, e0);
    wait_idle(0);
    chk_order(0);

    // Back-to-back: acc_last on the first IDLE edge after a complete drain.
    clear_mon(0);
    start_job(0, e0);
    b = 0;
    while (!(o_valid[0] && o_last[0] && out_ready) && b < 100) begin
      tick();
      b++;
    end
    tick();
    start_job(0, e0b);
    chk(0, "b2b_spacing", 32'(e0b - e0), 32'd9);
    chk(0, "b2b_busy",    32'(o_busy[0]), 32'd1);
    chk(0, "b2b_overrun", 32'(o_ovr[0]),  32'd0);
    clear_mon(0);
    wait_idle(0);
    chk_order(0);
    chk(0, "b2b_overrun_end", 32'(o_ovr[0]), 32'd0);

    repeat (3) tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
